// File: rtl/i2c_peripheral.sv
// I2C target: 7-bit address, byte write/read, open-drain sda, no stretching.
// Define I2C_PERIPHERAL_DEBUG_EN to flag ACK-drive cycles on debug.
module i2c_peripheral #(
  parameter logic [6:0] DEV_ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx,
  output logic [7:0] rx,
  output logic       rx_valid,
  output logic       rw,
  output logic       debug
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WRITE,
    WRITE_ACK, READ, READ_ACK, WAIT_STOP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [6:0]  sh_q, sh_d;
  logic [6:0]  txs_q, txs_d;
  logic        oe_q, oe_d;
  logic [7:0]  rx_d;
  logic        rxv_d, rw_d;
  logic [2:0]  scl_q, sda_q;
  logic        scl_s, scl_p, sda_s, sda_p;
  logic        scl_rise, scl_fall, start, stop;

  // Synchronizers track the bus even in reset so no false edge appears after it.
  always_ff @(posedge clk) begin
    scl_q <= {scl_q[1:0], scl};
    sda_q <= {sda_q[1:0], sda};
  end

  assign scl_s    = scl_q[1];
  assign scl_p    = scl_q[2];
  assign sda_s    = sda_q[1];
  assign sda_p    = sda_q[2];
  assign scl_rise = scl_s & ~scl_p;
  assign scl_fall = ~scl_s & scl_p;
  assign start    = scl_s & scl_p & sda_p & ~sda_s;
  assign stop     = scl_s & scl_p & ~sda_p & sda_s;

  assign sda = oe_q ? 1'b0 : 1'bz;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    txs_d   = txs_q;
    oe_d    = oe_q;
    rx_d    = rx;
    rxv_d   = 1'b0;
    rw_d    = rw;
    if (start) begin
      state_d = ADDR;
      cnt_d   = '0;
      oe_d    = 1'b0;
    end else if (stop) begin
      state_d = IDLE;
      oe_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, WAIT_STOP: ;
        ADDR: if (scl_rise) begin
          sh_d  = {sh_q[5:0], sda_s};
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d = '0;
            if (sh_q == DEV_ADDR) begin
              rw_d    = sda_s;
              state_d = ADDR_ACK;
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end
        // First fall starts the ACK, the second ends it.
        ADDR_ACK, WRITE_ACK: if (scl_fall) begin
          if (!oe_q) begin
            oe_d = 1'b1;
          end else if (state_q == ADDR_ACK && rw) begin
            state_d = READ;
            txs_d   = tx[6:0];
            oe_d    = ~tx[7];
          end else begin
            oe_d    = 1'b0;
            state_d = WRITE;
          end
        end
        WRITE: if (scl_rise) begin
          sh_d  = {sh_q[5:0], sda_s};
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d   = '0;
            rx_d    = {sh_q, sda_s};
            rxv_d   = 1'b1;
            state_d = WRITE_ACK;
          end
        end
        READ: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            oe_d    = 1'b0;
            cnt_d   = '0;
            state_d = READ_ACK;
          end else if (scl_fall && cnt_q != 4'd0) begin
            oe_d  = ~txs_q[6];
            txs_d = {txs_q[5:0], 1'b0};
          end
        end
        // cnt marks a controller ACK seen, waiting for the fall.
        READ_ACK: begin
          if (scl_rise) begin
            if (!sda_s) cnt_d = 4'd1;
            else state_d = WAIT_STOP;
          end else if (scl_fall && cnt_q == 4'd1) begin
            cnt_d   = '0;
            state_d = READ;
            txs_d   = tx[6:0];
            oe_d    = ~tx[7];
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sh_q     <= '0;
      txs_q    <= '0;
      oe_q     <= 1'b0;
      rx       <= '0;
      rx_valid <= 1'b0;
      rw       <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      txs_q    <= txs_d;
      oe_q     <= oe_d;
      rx       <= rx_d;
      rx_valid <= rxv_d;
      rw       <= rw_d;
    end
  end

`ifdef I2C_PERIPHERAL_DEBUG_EN
  assign debug = oe_q &
    (state_q == ADDR_ACK || state_q == WRITE_ACK);
`else
  assign debug = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_peripheral.sv
// Bench for i2c_peripheral: table of write transactions plus
// hand-written read, repeated-START and reset sequences.
module tb_i2c_peripheral;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic scl = 1'b1;
  logic m_low = 1'b0;
  logic [7:0] tx = 8'h00;
  logic [7:0] rx;
  logic rx_valid, rw, debug;
  wire sda;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  int checks = 0;
  int errors = 0;
  int rxv_n = 0;
  int dbg_viol = 0;
  logic [7:0] sb_q[$];

`ifdef I2C_PERIPHERAL_DEBUG_EN
  localparam logic DBG = 1'b1;
`else
  localparam logic DBG = 1'b0;
`endif

  i2c_peripheral #(.DEV_ADDR(7'h42)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda),
    .tx(tx), .rx(rx), .rx_valid(rx_valid),
    .rw(rw), .debug(debug)
  );

  always #5 clk = ~clk;

  // Scoreboard: every rx_valid pulse pops the oldest expected byte.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst && rx_valid) begin
      rxv_n++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: rx=%h, none expected", rx);
      end else begin
        e = sb_q.pop_front();
        if (rx !== e) begin
          errors++;
          $display("FAIL sb_rx: got %h want %h", rx, e);
        end
      end
    end
    if (debug && (!DBG || sda !== 1'b0)) dbg_viol++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic clk_bit(input logic v, output logic s, output logic d);
    tick(4); m_low = ~v;
    tick(4); scl = 1'b1;
    tick(4); s = sda; d = debug;
    tick(4); scl = 1'b0;
  endtask

  task automatic do_start();
    tick(4); m_low = 1'b0;
    tick(4); scl = 1'b1;
    tick(4); m_low = 1'b1;
    tick(4); scl = 1'b0;
  endtask

  task automatic do_stop();
    tick(4); m_low = 1'b1;
    tick(4); scl = 1'b1;
    tick(4); m_low = 1'b0;
    tick(4);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack,
                           output logic d);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s, d);
    clk_bit(1'b1, s, d);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic m_ack, input int chg,
                           input logic [7:0] nv, output logic [7:0] b);
    logic s, d;
    for (int i = 7; i >= 0; i--) begin
      if (i == chg) tx = nv;
      clk_bit(1'b1, s, d);
      b[i] = s;
    end
    clk_bit(~m_ack, s, d);
  endtask

  typedef struct {
    logic [7:0] abyte;
    logic [7:0] data;
    logic       ack;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic a, d, s;
    logic [7:0] b, exp_rx;
    logic exp_rw;
    int n0;
    vecs[0] = '{8'h84, 8'h67, 1'b1};
    vecs[1] = '{8'h86, 8'h55, 1'b0};
    vecs[2] = '{8'h84, 8'h00, 1'b1};
    vecs[3] = '{8'h84, 8'hFF, 1'b1};
    vecs[4] = '{8'h02, 8'h5A, 1'b0};
    vecs[5] = '{8'h84, 8'hA5, 1'b1};

    tick(4);
    chk("rst_rx", rx, 8'h00);
    chk("rst_rxv", 8'(rx_valid), 8'h00);
    chk("rst_rw", 8'(rw), 8'h00);
    chk("rst_dbg", 8'(debug), 8'h00);
    chk("rst_sda", 8'(sda), 8'h01);
    rst = 1'b1;
    tick(4);
    exp_rx = 8'h00;
    exp_rw = 1'b0;

    for (int i = 0; i < 6; i++) begin
      n0 = rxv_n;
      do_start();
      send_byte(vecs[i].abyte, a, d);
      chk($sformatf("v%0d_aack", i), 8'(a), 8'(vecs[i].ack));
      chk($sformatf("v%0d_adbg", i), 8'(d), 8'(DBG & vecs[i].ack));
      if (vecs[i].ack) sb_q.push_back(vecs[i].data);
      send_byte(vecs[i].data, a, d);
      chk($sformatf("v%0d_dack", i), 8'(a), 8'(vecs[i].ack));
      chk($sformatf("v%0d_ddbg", i), 8'(d), 8'(DBG & vecs[i].ack));
      do_stop();
      if (vecs[i].ack) begin
        exp_rx = vecs[i].data;
        exp_rw = vecs[i].abyte[0];
      end
      chk($sformatf("v%0d_rx", i), rx, exp_rx);
      chk($sformatf("v%0d_rw", i), 8'(rw), 8'(exp_rw));
      chk($sformatf("v%0d_nrxv", i), 8'(rxv_n - n0), 8'(vecs[i].ack));
      chk($sformatf("v%0d_sda", i), 8'(sda), 8'h01);
    end

    // Write then repeated-START read with NACK.
    do_start();
    send_byte(8'h84, a, d);
    chk("sr_aack1", 8'(a), 8'h01);
    sb_q.push_back(8'h67);
    send_byte(8'h67, a, d);
    chk("sr_dack", 8'(a), 8'h01);
    tx = 8'h66;
    do_start();
    send_byte(8'h85, a, d);
    chk("sr_aack2", 8'(a), 8'h01);
    chk("sr_adbg2", 8'(d), 8'(DBG));
    chk("sr_rw", 8'(rw), 8'h01);
    recv_byte(1'b0, -1, 8'h00, b);
    chk("sr_rd", b, 8'h66);
    tick(4);
    chk("sr_nack_sda", 8'(sda), 8'h01);
    do_stop();
    chk("sr_stop_sda", 8'(sda), 8'h01);
    chk("sr_rx", rx, 8'h67);

    // Two-byte read, tx changes during the first byte.
    tx = 8'hA5;
    do_start();
    send_byte(8'h85, a, d);
    chk("mr_aack", 8'(a), 8'h01);
    recv_byte(1'b1, 4, 8'h3C, b);
    chk("mr_b0", b, 8'hA5);
    recv_byte(1'b0, -1, 8'h00, b);
    chk("mr_b1", b, 8'h3C);
    do_stop();

    // Reset in the middle of a write data byte.
    n0 = rxv_n;
    do_start();
    send_byte(8'h84, a, d);
    chk("mrst_aack", 8'(a), 8'h01);
    clk_bit(1'b1, s, d);
    clk_bit(1'b1, s, d);
    clk_bit(1'b0, s, d);
    clk_bit(1'b0, s, d);
    m_low = 1'b0;
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    chk("mrst_rx", rx, 8'h00);
    chk("mrst_rw", 8'(rw), 8'h00);
    chk("mrst_rxv", 8'(rx_valid), 8'h00);
    chk("mrst_dbg", 8'(debug), 8'h00);
    chk("mrst_sda", 8'(sda), 8'h01);
    clk_bit(1'b0, s, d);
    clk_bit(1'b0, s, d);
    clk_bit(1'b1, s, d);
    clk_bit(1'b1, s, d);
    clk_bit(1'b1, s, d);
    chk("mrst_noack", 8'(s), 8'h01);
    do_stop();
    chk("mrst_nrxv", 8'(rxv_n - n0), 8'h00);
    chk("mrst_rx2", rx, 8'h00);

    do_start();
    send_byte(8'h84, a, d);
    chk("post_aack", 8'(a), 8'h01);
    sb_q.push_back(8'h11);
    send_byte(8'h11, a, d);
    chk("post_dack", 8'(a), 8'h01);
    do_stop();
    chk("post_rx", rx, 8'h11);

    chk("sb_left", 8'(sb_q.size()), 8'h00);
    chk("dbg_viol", 8'(dbg_viol), 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
